score_display_scan: RTL
=======================

# score_display_scan

Parametrised scoreboard display engine for the game's 7-segment readout. It captures CHANNELS binary scores, such as current score and high score, on a load strobe. It converts them to BCD with a serial shift-add-3 converter, saturates any score that does not fit, and time-multiplexes all digits onto a single shared segment bus with per-digit anode scanning. Compared with the earlier two-digit decoder, it adds configurable width, digit count and channel count, leading-zero blanking, overflow flagging, load queuing and optional blinking.

## Interface

Parameters:
- VALUE_W, 7: width of each binary score.
- DIGITS, 2: decimal digits per channel.
- CHANNELS, 2: number of scores shown.
- SCAN_DIV, 100000: clock cycles per digit slot.
- BLINK_FRAMES, 64: full scan frames per blink phase.

Ports (clock and reset first):
- clk, input, 1: system clock; everything is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- value, input, CHANNELS*VALUE_W: channel c occupies bits [c*VALUE_W +: VALUE_W].
- load, input, 1: capture-and-convert request, single-cycle strobe.
- blink, input, CHANNELS: per-channel blink request. It is used only when SCORE_BLINK_EN is defined.
- busy, output, 1: conversion in progress.
- overflow, output, CHANNELS: the last committed value for channel c exceeded 10^DIGITS−1.
- an, output, CHANNELS*DIGITS: anode enables, active-low, one-hot.
- seg, output, 7: segments {a,b,c,d,e,f,g} with a as the MSB, active-low.

## Operation

- The FSM has three states: IDLE, CONV and COMMIT.
- **IDLE:** when load=1, latch value into the capture register. Also set sat[c] = (value_c > 10^DIGITS−1), then go to CONV on channel 0.
- **CONV:** shift-add-3, one input bit per cycle, MSB first. This takes VALUE_W cycles per channel, with channels processed in order 0..CHANNELS−1. After the last bit of the last channel, go to COMMIT.
- **COMMIT:** write all channel BCD results into the display register in one cycle, so the update is atomic.
  - A channel with sat[c]=1 commits all digits as 9.
  - overflow is updated from sat in the same cycle.
  - Then go to IDLE, or back to CONV if a load is pending.
- **Load while busy:** set a single pending flag. At COMMIT, re-sample value and restart CONV; busy stays high throughout. Multiple loads while busy collapse into one.
- **Digit scanning:**
  - A divider counts 0..SCAN_DIV−1.
  - On wrap, the slot index advances modulo CHANNELS*DIGITS.
  - Slot index = c*DIGITS + d, where d=0 is the units digit.
  - an[slot]=0; all other anode bits are 1.
- **Digit decode (active-high, before inversion):** 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011.
- **Leading-zero blanking:**
  - Digit d of channel c is blanked (seg=1111111) when it and every higher digit of that channel is 0.
  - d=0 is never blanked.
  - Blanking is evaluated from the display register.

## Timing

- **Reset values:** busy=0, overflow=0, pending=0, display register all zeros, an all 1, seg=1111111, slot=0, divider=0, FSM in IDLE.
- **After reset release:** the first clk edge drives an[0]=0 with digit "0" (seg=0000001).
- **Conversion latency:** with load sampled at edge 0, busy is 1 from edge 0 until edge CHANNELS*VALUE_W+1. At that edge, the display register and overflow update and busy returns to 0.
- **Output path:** seg and an are registered and change together at a slot boundary or one cycle after COMMIT. There is no glitch between the two.
- **Reset mid-operation:** asserting rst_n at any point aborts the conversion, drops any pending load and returns everything to the reset values.

## Configuration

- **SCORE_BLINK_EN defined:**
  - A frame counter toggles a blink phase every BLINK_FRAMES complete scan frames; phase resets to 0.
  - While phase=1 and blink[c]=1, every slot of channel c outputs seg=1111111, and its anode still scans normally.
- **SCORE_BLINK_EN undefined:** the blink input is ignored, no frame counter is built, and digits are never blanked for blinking.

## Test plan

Default parameters, SCAN_DIV=4, BLINK_FRAMES=2.

1. **Reset:** hold rst_n=0 → an=1111, seg=1111111, busy=0. Release → an=1110, seg=0000001.
2. **Normal load:** load with ch0=42, ch1=7.
   - busy=1 for 15 cycles.
   - Slot 0 shows seg=0010010 ("2"); slot 1 shows "4" (1001100).
   - Slot 2 shows "7" (0001101); slot 3 is blanked (1111111).
3. **Saturation:** load ch0=127 → ch0 shows "99" and overflow=01. A following load of ch0=5 → overflow=00, and slot 1 is blanked.
4. **Load while busy:** load 10/20, then load 33/44 at cycle 5 → busy stays high for 30 cycles total, and the final display is 33/44. The intermediate 10/20 values are committed, then replaced.
5. **Reset mid-conversion:** assert rst_n at cycle 8 after a load → busy=0, the display reverts to 0/0, and no commit occurs after release.
6. **Blink (SCORE_BLINK_EN):** blink=10 → channel-1 slots are blank in alternating 2-frame phases while channel 0 stays lit. Without the macro, channel 1 is never blank.

Source files
------------

// File: rtl/score_display_scan.sv
// Multi-channel score readout: serial binary-to-BCD conversion with saturation, atomic commit,
// and scanned 7-segment output. Define SCORE_BLINK_EN to build the per-channel blink feature.
module score_display_scan #(
    parameter int VALUE_W      = 7,
    parameter int DIGITS       = 2,
    parameter int CHANNELS     = 2,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS*VALUE_W-1:0]   value,
    input  logic                          load,
    input  logic [CHANNELS-1:0]           blink,
    output logic                          busy,
    output logic [CHANNELS-1:0]           overflow,
    output logic [CHANNELS*DIGITS-1:0]    an,
    output logic [6:0]                    seg
);

    localparam int SLOTS  = CHANNELS * DIGITS;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BIT_W  = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BCD_W  = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110010;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // One shift-add-3 step: correct every digit >= 5, then shift the next binary bit in.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] a, input logic b);
        logic [BCD_W-1:0] t;
        t = a;
        for (int unsigned d = 0; d < DIGITS; d++)
            if (t[d*4 +: 4] >= 4'd5) t[d*4 +: 4] = t[d*4 +: 4] + 4'd3;
        return {t[BCD_W-2:0], b};
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t                      state;
    logic [CHANNELS*VALUE_W-1:0] cap;
    logic [CHANNELS-1:0]         sat;
    logic                        pending;
    logic [CH_W-1:0]             ch;
    logic [BIT_W-1:0]            bit_idx;
    logic [BCD_W-1:0]            acc;
    logic [CHANNELS*BCD_W-1:0]   res;
    logic [CHANNELS*BCD_W-1:0]   disp;

    logic [CHANNELS-1:0]         value_sat;
    logic                        cur_bit;
    logic [BCD_W-1:0]            acc_next;
    logic [CHANNELS*BCD_W-1:0]   commit_bcd;

    always_comb begin
        value_sat = '0;
        for (int unsigned c = 0; c < CHANNELS; c++)
            value_sat[c] = 64'(value[c*VALUE_W +: VALUE_W]) > MAX_DEC;
    end

    always_comb begin
        cur_bit = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++)
            for (int unsigned b = 0; b < VALUE_W; b++)
                if (ch == CH_W'(c) && bit_idx == BIT_W'(VALUE_W - 1 - b))
                    cur_bit = cap[c*VALUE_W + b];
    end

    assign acc_next = dd_step(acc, cur_bit);

    always_comb begin
        commit_bcd = '0;
        for (int unsigned c = 0; c < CHANNELS; c++)
            commit_bcd[c*BCD_W +: BCD_W] = sat[c] ? {DIGITS{4'd9}} : res[c*BCD_W +: BCD_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap      <= '0;
            sat      <= '0;
            pending  <= 1'b0;
            ch       <= '0;
            bit_idx  <= '0;
            acc      <= '0;
            res      <= '0;
            disp     <= '0;
            busy     <= 1'b0;
            overflow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        cap     <= value;
                        sat     <= value_sat;
                        ch      <= '0;
                        bit_idx <= '0;
                        acc     <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (load) pending <= 1'b1;
                    if (bit_idx == BIT_W'(VALUE_W - 1)) begin
                        for (int unsigned c = 0; c < CHANNELS; c++)
                            if (ch == CH_W'(c)) res[c*BCD_W +: BCD_W] <= acc_next;
                        acc     <= '0;
                        bit_idx <= '0;
                        if (ch == CH_W'(CHANNELS - 1)) state <= COMMIT;
                        else                           ch    <= ch + 1'b1;
                    end else begin
                        acc     <= acc_next;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    disp     <= commit_bcd;
                    overflow <= sat;
                    // A load arriving in the commit cycle itself is folded into the pending restart.
                    if (pending || load) begin
                        pending <= 1'b0;
                        cap     <= value;
                        sat     <= value_sat;
                        ch      <= '0;
                        bit_idx <= '0;
                        acc     <= '0;
                        state   <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot;
    logic              div_wrap;

    assign div_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            slot    <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            slot    <= (slot == SLOT_W'(SLOTS - 1)) ? '0 : slot + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FR_W-1:0] frame_cnt;
    logic            phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (div_wrap && slot == SLOT_W'(SLOTS - 1)) begin
            if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink;
`endif

    logic [3:0] cur_digit;
    logic       upper_zero;
    logic       lz_blank;
    logic       blink_blank;

    always_comb begin
        cur_digit   = '0;
        upper_zero  = 1'b1;
        lz_blank    = 1'b0;
        blink_blank = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (slot == SLOT_W'(c*DIGITS + d)) begin
                    cur_digit  = disp[(c*DIGITS + d)*4 +: 4];
                    upper_zero = 1'b1;
                    for (int unsigned k = d; k < DIGITS; k++)
                        if (disp[(c*DIGITS + k)*4 +: 4] != 4'd0) upper_zero = 1'b0;
                    lz_blank = (d != 0) && upper_zero;
`ifdef SCORE_BLINK_EN
                    blink_blank = phase & blink[c];
`endif
                end
            end
        end
    end

    // Anode and segment share one register stage so they always switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= ~(SLOTS'(1) << slot);
            seg <= (lz_blank || blink_blank) ? 7'b1111111 : ~seg_pattern(cur_digit);
        end
    end

endmodule
